// File: rtl/voq_sched_ctrl.sv
// VOQ occupancy tracking and arbitration-round sequencing in front of the
// crossbar priority scheduler: snapshot, start, validate decision, apply slot.
module voq_sched_ctrl #(
  parameter int N           = 4,
  parameter int P           = 16,
  parameter int CW          = 8,
  parameter int SLOT_CYCLES = 4,
  parameter int TIMEOUT     = 64,
  localparam int LN = $clog2(N),
  localparam int PW = $clog2(P)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N-1:0]         arr_valid,
  input  logic [N*LN-1:0]      arr_dest,
  output logic                 sched_start,
  output logic [N*N*PW-1:0]    sched_pri_req,
  input  logic [N*N-1:0]       sched_decision,
  input  logic                 sched_done,
  output logic [N*N-1:0]       xbar_cfg,
  output logic                 xbar_valid,
  output logic [N*N-1:0]       deq,
  output logic                 err_ovf,
  output logic                 err_illegal,
  output logic                 err_timeout
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SW = $clog2(SLOT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_APPLY} state_t;

  state_t              r_state, w_state_next;
  logic [TW-1:0]       r_wait, w_wait_next;
  logic [SW-1:0]       r_slot, w_slot_next;
  logic [CW-1:0]       r_cnt [N*N];
  logic [N*N*PW-1:0]   r_pri, w_pri;
  logic [N*N-1:0]      r_cfg;
  logic                r_err_ovf, r_err_illegal, r_err_timeout;

  logic [N*N-1:0]      w_arr, w_deq, w_sat, w_cnt_nz, w_snap_nz, w_row_keep, w_valid;
  logic [N-1:0][N-1:0] w_row_low, w_col_bits, w_col_low;
  logic                w_any, w_snap, w_load_cfg, w_timeout;

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      // Isolate the lowest-j raw grant of each input row.
      assign w_row_low[gi] = sched_decision[gi*N +: N] & (~sched_decision[gi*N +: N] + N'(1));
      for (gj = 0; gj < N; gj++) begin : g_elem
        localparam int K = gi*N + gj;
        assign w_arr[K]      = arr_valid[gi] && (arr_dest[gi*LN +: LN] == LN'(gj));
        assign w_cnt_nz[K]   = |r_cnt[K];
        assign w_sat[K]      = &r_cnt[K];
        assign w_pri[K*PW +: PW] = (r_cnt[K] > CW'(P-1)) ? PW'(P-1) : r_cnt[K][PW-1:0];
        assign w_snap_nz[K]  = |r_pri[K*PW +: PW];
        assign w_row_keep[K] = w_row_low[gi][gj] & w_snap_nz[K];
        assign w_col_bits[gj][gi] = w_row_keep[K];
        assign w_valid[K]    = w_col_low[gj][gi];
      end
    end
    for (gj = 0; gj < N; gj++) begin : g_col
      assign w_col_low[gj] = w_col_bits[gj] & (~w_col_bits[gj] + N'(1));
    end
  endgenerate

  assign w_any = |w_cnt_nz;
  assign w_deq = (r_state == S_APPLY && r_slot == '0) ? r_cfg : '0;

  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait;
    w_slot_next  = r_slot;
    w_snap       = 1'b0;
    w_load_cfg   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && w_any) begin
          w_state_next = S_REQ;
          w_snap       = 1'b1;
        end
      end
      S_REQ: begin
        w_state_next = S_WAIT;
        w_wait_next  = '0;
      end
      S_WAIT: begin
        if (sched_done) begin
          w_state_next = S_APPLY;
          w_slot_next  = '0;
          w_load_cfg   = 1'b1;
        end else if (r_wait == TW'(TIMEOUT-1)) begin
          w_state_next = S_IDLE;
          w_timeout    = 1'b1;
        end else begin
          w_wait_next  = r_wait + TW'(1);
        end
      end
      S_APPLY: begin
        // Slot index SLOT_CYCLES is the reconfiguration gap with the crossbar off.
        if (r_slot == SW'(SLOT_CYCLES)) begin
          if (enable && w_any) begin
            w_state_next = S_REQ;
            w_snap       = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_slot_next = r_slot + SW'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_wait        <= '0;
      r_slot        <= '0;
      r_pri         <= '0;
      r_cfg         <= '0;
      r_err_ovf     <= 1'b0;
      r_err_illegal <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
      r_slot  <= w_slot_next;
      if (w_snap)     r_pri <= w_pri;
      if (w_load_cfg) r_cfg <= w_valid;
      if (w_load_cfg && (w_valid != sched_decision)) r_err_illegal <= 1'b1;
      if (w_timeout)  r_err_timeout <= 1'b1;
      if (|(w_arr & ~w_deq & w_sat)) r_err_ovf <= 1'b1;
    end
  end

  // A simultaneous arrival and dequeue on one VOQ cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N*N; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N*N; k++) begin
        if (w_arr[k] && !w_deq[k] && !w_sat[k])
          r_cnt[k] <= r_cnt[k] + CW'(1);
        else if (!w_arr[k] && w_deq[k])
          r_cnt[k] <= r_cnt[k] - CW'(1);
      end
    end
  end

  assign sched_start   = (r_state == S_REQ);
  assign sched_pri_req = r_pri;
  assign xbar_valid    = (r_state == S_APPLY) && (r_slot < SW'(SLOT_CYCLES));
  assign xbar_cfg      = xbar_valid ? r_cfg : '0;
  assign deq           = w_deq;
  assign err_ovf       = r_err_ovf;
  assign err_illegal   = r_err_illegal;
  assign err_timeout   = r_err_timeout;

endmodule

// File: doc/voq_sched_ctrl.md
Name: voq_sched_ctrl

Overview:
- Front-end controller for the crossbar priority scheduler.
- Keeps N×N virtual-output-queue (VOQ) occupancy counters and turns them into priority requests for the scheduler.
- Sequences each arbitration round: snapshot, start, wait for the decision, sanity-check the decision, then apply the crossbar configuration for a fixed slot and dequeue the granted VOQs.

Parameters:
N, 4, number of ports (inputs = outputs); power of 2, ≥2
P, 16, priority levels; request field width PW = $clog2(P)
CW, 8, VOQ occupancy counter width
SLOT_CYCLES, 4, cycles a crossbar configuration is held (≥1)
TIMEOUT, 64, max cycles to wait for the scheduler decision

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = run arbitration rounds; 0 = finish the current round, then stay in IDLE
arr_valid  in  N  bit i: one cell arrives at input i this cycle
arr_dest  in  N*$clog2(N)  field i: destination output of the input-i arrival
sched_start  out  1  one-cycle pulse that starts the scheduler
sched_pri_req  out  N*N*PW  field (i*N+j): priority of VOQ[i][j]; 0 = no request
sched_decision  in  N*N  bit (i*N+j): input i granted to output j
sched_done  in  1  one-cycle pulse; sched_decision is valid in this cycle
xbar_cfg  out  N*N  applied crossbar matrix, same bit layout as sched_decision
xbar_valid  out  1  xbar_cfg is live
deq  out  N*N  one-cycle pulse: dequeue one cell from VOQ[i][j]
err_ovf  out  1  sticky: an arrival hit a saturated counter
err_illegal  out  1  sticky: decision had illegal bits
err_timeout  out  1  sticky: sched_done did not arrive within TIMEOUT

Behaviour:
- Reset (asynchronous, any state, including mid-round): state=IDLE; all counters, xbar_cfg, deq, sched_pri_req, sched_start, xbar_valid and error flags = 0. Errors clear only on reset.
- Arrivals are accepted in every state. For each i with arr_valid[i]=1, cnt[i][arr_dest[i]] increments.
  - Saturates at 2^CW−1. An arrival at saturation sets err_ovf and leaves cnt unchanged.
- Priority of VOQ[i][j] = min(cnt[i][j], P−1), so cnt=0 gives 0 (no request).
- FSM states: IDLE, REQ, WAIT, APPLY.
- IDLE:
  - enable=1 and any cnt≠0 → REQ.
  - Otherwise stay in IDLE with xbar_valid=0.
- REQ (1 cycle):
  - Register the snapshot of all priorities into sched_pri_req. It is held constant until the next REQ.
  - Assert sched_start=1 during this cycle only.
  - → WAIT with wait counter = 0.
- WAIT:
  - Increment the wait counter each cycle.
  - sched_done=1 → validate the decision and → APPLY.
  - Counter reaches TIMEOUT−1 with no sched_done → set err_timeout and → IDLE; xbar_cfg stays 0.
  - sched_done outside WAIT is ignored.
- Validation (in the sched_done cycle): bit (i,j) is kept only if all of the following hold:
  - the snapshot priority of (i,j) is ≠ 0;
  - it is the lowest-j set bit in row i;
  - it is the lowest-i surviving bit in column j.
  - Any dropped bit sets err_illegal.
  - The result is therefore always a partial permutation.
- APPLY entry (registered, one cycle after sched_done):
  - xbar_cfg = validated matrix, xbar_valid = 1.
  - deq = validated matrix for exactly this one cycle.
  - Each granted cnt decrements by 1 in the same cycle.
  - An arrival to the same VOQ in the same cycle leaves the net count unchanged.
  - Decrement never underflows: an arrival-only counter that reached 0 cannot be granted.
- APPLY holds for SLOT_CYCLES cycles, then:
  - xbar_valid = 0 and xbar_cfg = 0 for one cycle (the reconfiguration gap);
  - → REQ if enable=1 and any cnt≠0, else → IDLE.
- An all-zero validated decision still occupies the APPLY slot, with xbar_valid=1 and xbar_cfg=0.
- enable falling mid-round does not abort the round; it is sampled only at the IDLE and APPLY exits.
- Latency:
  - arrival → visible in the snapshot: 1 cycle;
  - sched_done → xbar_valid: 1 cycle;
  - round length = 1 + wait + SLOT_CYCLES + 1 cycles.

Test Plan:
- N=4, single arrival to VOQ[0][2], enable=1 → sched_start pulses, pri field (0,2)=1, all others 0. Return decision bit 2 → xbar_cfg=0x0004 for 4 cycles, deq[2] pulses once, cnt[0][2]=0, back to IDLE.
- 20 arrivals to VOQ[1][3] → pri field (1,3)=15 (saturated at P−1). 255 more arrivals → cnt=255 and err_ovf=1.
- Return decision 0x0003 (row 0 has two bits), both VOQs nonempty → applied xbar_cfg=0x0001, err_illegal=1. Grant to an empty VOQ → bit dropped, err_illegal=1.
- Never pulse sched_done → after 64 WAIT cycles err_timeout=1, state=IDLE, xbar_valid=0. Next round starts normally.
- APPLY-entry cycle: arrival to the granted VOQ[2][1] with cnt=3 → cnt stays 3, deq bit (2,1)=1.
- Assert reset during APPLY → xbar_valid, xbar_cfg and all counters = 0 immediately, without waiting for a clock edge. With enable=1 and no arrivals, no sched_start appears afterwards.
